// File: rtl/eth_decap_pkg.sv
// Shared types and header layout for the Ethernet encapsulation/decapsulation path.
package eth_decap_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_PAYLOAD,
    S_HOLD,
    S_ABORT,
    S_DISCARD
  } state_t;

  localparam int ETYPE_OFF   = 12;
  localparam int LEN_OFF     = 14;
  localparam int PAYLOAD_OFF = 16;

  // 74-bit FIFO word: [73] err, [72] last, [71:64] keep, [63:0] data
  typedef struct packed {
    logic        err;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } fifo_word_t;

endpackage

// File: rtl/eth_decap.sv
// Receive decapsulation: filters on dst MAC/EtherType, strips the 16-byte header, trims to L.
// Define ETH_DECAP_STATS_EN to add saturating stat_frames/stat_drops/stat_errs counters.
module eth_decap
  import eth_decap_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h000A35000001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [15:0] MAX_LEN   = 16'd1500
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  input  logic        full,
`ifdef ETH_DECAP_STATS_EN
  output logic [31:0] stat_frames,
  output logic [31:0] stat_drops,
  output logic [31:0] stat_errs,
`endif
  output logic        wr_en,
  output logic [73:0] din
);

  // Bit positions of header fields inside the second header beat
  localparam int HB_BASE = PAYLOAD_OFF - 8;
  localparam int ET_BIT  = (ETYPE_OFF - HB_BASE) * 8;
  localparam int LEN_BIT = (LEN_OFF - HB_BASE) * 8;

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction

  function automatic fifo_word_t mk_word(input logic err, input logic last,
                                         input logic [7:0] keep, input logic [63:0] data);
    fifo_word_t w;
    w.err  = err;
    w.last = last;
    w.keep = keep;
    w.data = data;
    return w;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [47:0] r_dst, w_dst_nxt;
  logic [15:0] r_rem, w_rem_nxt;
  logic [63:0] r_hold_data, w_hold_data_nxt;
  logic [7:0]  r_hold_keep, w_hold_keep_nxt;
  logic        r_wrote, w_wrote_nxt;
  logic        r_last_seen, w_last_seen_nxt;
  logic        r_wr_en;
  fifo_word_t  r_din;

  logic        w_wr, w_need, w_tl, w_hdr_bad;
  fifo_word_t  w_din, w_cand;
  state_t      w_after;
  logic [15:0] w_etype, w_len;
  logic [63:0] w_d;

  assign w_d      = s_axis_rx_tdata;
  assign w_tl     = s_axis_rx_tvalid && s_axis_rx_tlast;
  assign w_etype  = {w_d[ET_BIT +: 8], w_d[ET_BIT+8 +: 8]};
  assign w_len    = {w_d[LEN_BIT +: 8], w_d[LEN_BIT+8 +: 8]};
  assign w_hdr_bad = (w_etype != ETHERTYPE) || (w_len == 16'd0) || (w_len > MAX_LEN) ||
                     !((r_dst == MY_MAC) || (r_dst == 48'hFFFF_FFFF_FFFF));

  always_comb begin
    w_state_nxt     = r_state;
    w_dst_nxt       = r_dst;
    w_rem_nxt       = r_rem;
    w_hold_data_nxt = r_hold_data;
    w_hold_keep_nxt = r_hold_keep;
    w_wrote_nxt     = r_wrote;
    w_last_seen_nxt = r_last_seen;
    w_wr            = 1'b0;
    w_din           = '0;
    w_need          = 1'b0;
    w_cand          = '0;
    w_after         = S_IDLE;

    case (r_state)
      S_IDLE: if (s_axis_rx_tvalid) begin
        w_dst_nxt   = {w_d[7:0], w_d[15:8], w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]};
        w_wrote_nxt = 1'b0;
        w_state_nxt = s_axis_rx_tlast ? S_IDLE : S_HDR1;
      end
      // A frame ending on the header beat has no payload and is dropped too
      S_HDR1: if (s_axis_rx_tvalid) begin
        if (w_hdr_bad || s_axis_rx_tlast) begin
          w_state_nxt = s_axis_rx_tlast ? S_IDLE : S_DISCARD;
        end else begin
          w_rem_nxt   = w_len;
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (s_axis_rx_tvalid) begin
        if (r_rem > 16'd8) begin
          w_need = 1'b1;
          if (s_axis_rx_tlast) begin
            w_cand  = mk_word(1'b1, 1'b1, s_axis_rx_tkeep, w_d);
            w_after = S_IDLE;
          end else begin
            w_cand    = mk_word(1'b0, 1'b0, 8'hFF, w_d);
            w_after   = S_PAYLOAD;
            w_rem_nxt = r_rem - 16'd8;
          end
        end else begin
          w_hold_data_nxt = w_d;
          w_hold_keep_nxt = keep_mask(r_rem[3:0]);
          if (s_axis_rx_tlast) begin
            w_need  = 1'b1;
            w_cand  = mk_word(!s_axis_rx_tuser, 1'b1, keep_mask(r_rem[3:0]), w_d);
            w_after = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: if (w_tl) begin
        w_need  = 1'b1;
        w_cand  = mk_word(!s_axis_rx_tuser, 1'b1, r_hold_keep, r_hold_data);
        w_after = S_IDLE;
      end
      // Terminator does not wait on tvalid: the frame may already be over
      S_ABORT: begin
        w_last_seen_nxt = r_last_seen || w_tl;
        if (!full) begin
          w_wr        = 1'b1;
          w_din       = mk_word(1'b1, 1'b1, 8'h00, 64'h0);
          w_state_nxt = (r_last_seen || w_tl) ? S_IDLE : S_DISCARD;
        end
      end
      S_DISCARD: if (w_tl) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_need) begin
      if (!full) begin
        w_wr        = 1'b1;
        w_din       = w_cand;
        w_state_nxt = w_after;
        w_wrote_nxt = 1'b1;
      end else if (!r_wrote) begin
        w_state_nxt = w_tl ? S_IDLE : S_DISCARD;
      end else begin
        w_state_nxt     = S_ABORT;
        w_last_seen_nxt = w_tl;
      end
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_dst       <= '0;
      r_rem       <= '0;
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_wrote     <= 1'b0;
      r_last_seen <= 1'b0;
      r_wr_en     <= 1'b0;
      r_din       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dst       <= w_dst_nxt;
      r_rem       <= w_rem_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_hold_keep <= w_hold_keep_nxt;
      r_wrote     <= w_wrote_nxt;
      r_last_seen <= w_last_seen_nxt;
      r_wr_en     <= w_wr;
      r_din       <= w_din;
    end
  end

  assign wr_en = r_wr_en;
  assign din   = r_din;

`ifdef ETH_DECAP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        w_drop;
  logic [31:0] r_frames, r_drops, r_errs;

  assign w_drop = (s_axis_rx_tvalid && (((r_state == S_IDLE) && s_axis_rx_tlast) ||
                  ((r_state == S_HDR1) && (w_hdr_bad || s_axis_rx_tlast)))) ||
                  (w_need && full && !r_wrote);

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frames <= '0;
      r_drops  <= '0;
      r_errs   <= '0;
    end else begin
      if (w_wr && w_din.last && !w_din.err) r_frames <= sat_inc(r_frames);
      if (w_wr && w_din.last && w_din.err)  r_errs   <= sat_inc(r_errs);
      if (w_drop)                           r_drops  <= sat_inc(r_drops);
    end
  end

  assign stat_frames = r_frames;
  assign stat_drops  = r_drops;
  assign stat_errs   = r_errs;
`endif

endmodule

// File: tb/tb_eth_decap.sv
// Scoreboard bench for eth_decap: directed frames push expected FIFO words, a monitor checks them.
module tb_eth_decap;

  localparam logic [47:0] MY_MAC = 48'h000A35000001;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] ET     = 16'h88B5;

  logic        clk156 = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        s_axis_rx_tvalid = 1'b0;
  logic [63:0] s_axis_rx_tdata = '0;
  logic [7:0]  s_axis_rx_tkeep = '0;
  logic        s_axis_rx_tlast = 1'b0;
  logic        s_axis_rx_tuser = 1'b0;
  logic        full = 1'b0;
  logic        wr_en;
  logic [73:0] din;
`ifdef ETH_DECAP_STATS_EN
  logic [31:0] stat_frames, stat_drops, stat_errs;
`endif

  eth_decap dut (
    .clk156          (clk156),
    .sys_rst_n       (sys_rst_n),
    .s_axis_rx_tvalid(s_axis_rx_tvalid),
    .s_axis_rx_tdata (s_axis_rx_tdata),
    .s_axis_rx_tkeep (s_axis_rx_tkeep),
    .s_axis_rx_tlast (s_axis_rx_tlast),
    .s_axis_rx_tuser (s_axis_rx_tuser),
    .full            (full),
`ifdef ETH_DECAP_STATS_EN
    .stat_frames     (stat_frames),
    .stat_drops      (stat_drops),
    .stat_errs       (stat_errs),
`endif
    .wr_en           (wr_en),
    .din             (din)
  );

  always #5 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  typedef struct {
    logic [73:0] w;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c0 = 0;

  function automatic logic [63:0] hdr0(input logic [47:0] dst);
    logic [63:0] d;
    d = 64'h0;
    for (int b = 0; b < 6; b++) d[8*b +: 8] = dst[8*(5-b) +: 8];
    d[63:48] = 16'h0200;
    return d;
  endfunction

  function automatic logic [63:0] hdr1(input logic [15:0] et, input logic [15:0] len);
    logic [63:0] d;
    d = 64'h0000_0000_0055_0000;
    d[39:32] = et[15:8];
    d[47:40] = et[7:0];
    d[55:48] = len[15:8];
    d[63:56] = len[7:0];
    return d;
  endfunction

  function automatic logic [63:0] pdata(input int fid, input int k);
    return {8'(fid), 8'(k), 48'hC0FFEE123456};
  endfunction

  task automatic expw(input logic err, input logic last, input logic [7:0] keep,
                      input logic [63:0] data, input int k);
    exp_t e;
    e.w   = {err, last, keep, data};
    e.cyc = c0 + k + 1;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [73:0] got, input logic [73:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] keep,
                            input logic last, input logic user);
    s_axis_rx_tvalid = 1'b1;
    s_axis_rx_tdata  = d;
    s_axis_rx_tkeep  = keep;
    s_axis_rx_tlast  = last;
    s_axis_rx_tuser  = user;
    @(posedge clk156);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  // Frame of nb beats; full is high while beats ff..ff+fn-1 are presented
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] len,
                            input int nb, input logic [7:0] lkeep, input logic user,
                            input int fid, input int ff, input int fn);
    for (int k = 0; k < nb; k++) begin
      logic [63:0] d;
      if (k == 0)      d = hdr0(dst);
      else if (k == 1) d = hdr1(et, len);
      else             d = pdata(fid, k);
      full = (k >= ff) && (k < ff + fn);
      drive_beat(d, (k == nb - 1) ? lkeep : 8'hFF, k == nb - 1, user);
    end
    full = 1'b0;
  endtask

  always @(negedge clk156) begin
    if (wr_en) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got din=%h at cyc %0d, want no write", din, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (din !== e.w || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL fifo_word: got din=%h cyc=%0d, want din=%h cyc=%0d", din, cyc, e.w, e.cyc);
        end
      end
    end
  end

  initial begin
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    chk("reset_wr_en", {73'h0, wr_en}, 74'h0);
    chk("reset_din", din, 74'h0);
    @(negedge clk156);
    sys_rst_n = 1'b1;
    @(posedge clk156);
    #1;

    // L=20 padded 64-byte frame, then L=16 ending on beat 3 with bad FCS, back to back
    c0 = cyc;
    expw(0, 0, 8'hFF, pdata(1, 2), 2);
    expw(0, 0, 8'hFF, pdata(1, 3), 3);
    expw(0, 1, 8'h0F, pdata(1, 4), 7);
    send_frame(MY_MAC, ET, 16'd20, 8, 8'hFF, 1'b1, 1, 0, 0);
    c0 = cyc;
    expw(0, 0, 8'hFF, pdata(2, 2), 2);
    expw(1, 1, 8'hFF, pdata(2, 3), 3);
    send_frame(MY_MAC, ET, 16'd16, 4, 8'hFF, 1'b0, 2, 0, 0);

    // Filter drops, broadcast accept, length bounds
    send_frame(MY_MAC, 16'h0800, 16'd20, 4, 8'hFF, 1'b1, 3, 0, 0);
    send_frame(48'h020000000009, ET, 16'd20, 4, 8'hFF, 1'b1, 4, 0, 0);
    c0 = cyc;
    expw(0, 1, 8'hFF, pdata(5, 2), 2);
    send_frame(BCAST, ET, 16'd8, 3, 8'hFF, 1'b1, 5, 0, 0);
    send_frame(MY_MAC, ET, 16'd0, 4, 8'hFF, 1'b1, 6, 0, 0);
    send_frame(MY_MAC, ET, 16'd1501, 4, 8'hFF, 1'b1, 7, 0, 0);
    idle(2);

    // FIFO full mid-frame: terminator once full drops, rest discarded
    c0 = cyc;
    expw(0, 0, 8'hFF, pdata(8, 2), 2);
    expw(0, 0, 8'hFF, pdata(8, 3), 3);
    expw(1, 1, 8'h00, 64'h0, 7);
    send_frame(MY_MAC, ET, 16'd64, 10, 8'hFF, 1'b1, 8, 4, 3);
    c0 = cyc;
    expw(0, 1, 8'hFF, pdata(9, 2), 2);
    send_frame(MY_MAC, ET, 16'd8, 3, 8'hFF, 1'b1, 9, 0, 0);
    // Full on the very first payload write: silent drop
    send_frame(MY_MAC, ET, 16'd64, 10, 8'hFF, 1'b1, 10, 2, 1);
    idle(1);

    // Truncated by MAC tlast at byte 40
    c0 = cyc;
    expw(0, 0, 8'hFF, pdata(11, 2), 2);
    expw(0, 0, 8'hFF, pdata(11, 3), 3);
    expw(0, 0, 8'hFF, pdata(11, 4), 4);
    expw(1, 1, 8'h01, pdata(11, 5), 5);
    send_frame(MY_MAC, ET, 16'd64, 6, 8'h01, 1'b1, 11, 0, 0);
    idle(2);
`ifdef ETH_DECAP_STATS_EN
    chk("stat_frames", {42'h0, stat_frames}, 74'd3);
    chk("stat_drops", {42'h0, stat_drops}, 74'd5);
    chk("stat_errs", {42'h0, stat_errs}, 74'd3);
`endif

    // Reset pulsed while a frame is in flight and a write is on the output
    c0 = cyc;
    expw(0, 0, 8'hFF, pdata(12, 2), 2);
    drive_beat(hdr0(MY_MAC), 8'hFF, 1'b0, 1'b1);
    drive_beat(hdr1(ET, 16'd64), 8'hFF, 1'b0, 1'b1);
    drive_beat(pdata(12, 2), 8'hFF, 1'b0, 1'b1);
    s_axis_rx_tvalid = 1'b0;
    @(negedge clk156);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", {73'h0, wr_en}, 74'h0);
    chk("midrst_din", din, 74'h0);
    idle(2);
    @(negedge clk156);
    sys_rst_n = 1'b1;
    @(posedge clk156);
    #1;

    c0 = cyc;
    expw(0, 0, 8'hFF, pdata(13, 2), 2);
    expw(0, 1, 8'h0F, pdata(13, 3), 3);
    send_frame(MY_MAC, ET, 16'd12, 4, 8'hFF, 1'b1, 13, 0, 0);
    idle(4);
`ifdef ETH_DECAP_STATS_EN
    chk("stat_frames_after_rst", {42'h0, stat_frames}, 74'd1);
    chk("stat_drops_after_rst", {42'h0, stat_drops}, 74'd0);
    chk("stat_errs_after_rst", {42'h0, stat_errs}, 74'd0);
`endif
    chk("sb_drain", 74'(sb_q.size()), 74'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
